// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the Y86-64 pipeline datapath and its control unit.
// The datapath side is the master; the control unit is the slave.
interface pipe_ctrl_if #(parameter int CNT_W = 32);
    logic [3:0]       D_icode;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [3:0]       E_icode;
    logic [3:0]       E_dstM;
    logic             e_cnd;
    logic             e_zf;
    logic             e_sf;
    logic             e_of;
    logic [3:0]       M_icode;
    logic [3:0]       m_stat;
    logic [3:0]       W_stat;
    logic             F_stall;
    logic             D_stall;
    logic             W_stall;
    logic             D_bubble;
    logic             E_bubble;
    logic             M_bubble;
    logic             cc_zf;
    logic             cc_sf;
    logic             cc_of;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_cnd, e_zf, e_sf, e_of,
               M_icode, m_stat, W_stat,
        input  F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble,
               cc_zf, cc_sf, cc_of, halted, stall_cnt, bubble_cnt, mispred_cnt
    );

    modport slave (
        input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_cnd, e_zf, e_sf, e_of,
               M_icode, m_stat, W_stat,
        output F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble,
               cc_zf, cc_sf, cc_of, halted, stall_cnt, bubble_cnt, mispred_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: hazard stall/bubble generation, condition-code register,
// halt/exception shutdown sequencing and saturating performance counters.
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    pipe_ctrl_if.slave bus
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [3:0] S_AOK    = 4'h1;

    state_t           state_r;
    logic [2:0]       cc_r;
    logic             halted_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] bubble_cnt_r;
    logic [CNT_W-1:0] mispred_cnt_r;

    logic lu_s, ret_s, mp_s, set_cc_s;
    logic f_stall_s, d_stall_s, w_stall_s, d_bubble_s, e_bubble_s, m_bubble_s;

    function automatic logic exc_f(input logic [3:0] stat);
        return stat != S_AOK;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_f(input logic [CNT_W-1:0] val, input logic en);
        logic [CNT_W-1:0] res;
        if (en && (val != {CNT_W{1'b1}})) begin
            res = val + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            res = val;
        end
        return res;
    endfunction

    // Hazard detection terms evaluated on the current stage contents.
    always_comb begin
        lu_s     = ((bus.E_icode == I_MRMOVQ) || (bus.E_icode == I_POPQ)) &&
                   (bus.E_dstM != R_NONE) &&
                   ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
        ret_s    = (bus.D_icode == I_RET) || (bus.E_icode == I_RET) || (bus.M_icode == I_RET);
        mp_s     = (bus.E_icode == I_JXX) && !bus.e_cnd;
        set_cc_s = (state_r == ST_RUN) && (bus.E_icode == I_OPQ) &&
                   !exc_f(bus.m_stat) && !exc_f(bus.W_stat);
    end

    // Pipeline-register controls; forced quiet while reset is asserted.
    always_comb begin
        f_stall_s  = 1'b0;
        d_stall_s  = 1'b0;
        w_stall_s  = 1'b0;
        d_bubble_s = 1'b0;
        e_bubble_s = 1'b0;
        m_bubble_s = 1'b0;
        if (!rst_n) begin
            f_stall_s  = 1'b0;
            d_bubble_s = 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    f_stall_s  = lu_s || ret_s;
                    d_stall_s  = lu_s;
                    // A bubble overrides a concurrent decode stall when both are raised.
                    d_bubble_s = mp_s || (!lu_s && ret_s);
                    e_bubble_s = mp_s || lu_s;
                    m_bubble_s = exc_f(bus.m_stat) || exc_f(bus.W_stat);
                    w_stall_s  = exc_f(bus.W_stat);
                end
                ST_HALTED: begin
                    f_stall_s  = 1'b1;
                    d_stall_s  = 1'b1;
                    w_stall_s  = 1'b1;
                    e_bubble_s = 1'b1;
                    m_bubble_s = 1'b1;
                end
                default: begin
                    f_stall_s  = 1'b1;
                    d_stall_s  = 1'b1;
                    w_stall_s  = 1'b1;
                    e_bubble_s = 1'b1;
                    m_bubble_s = 1'b1;
                end
            endcase
        end
    end

    // Run/halt sequencing, condition codes and performance counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_RUN;
            cc_r          <= 3'b100;
            halted_r      <= 1'b0;
            stall_cnt_r   <= {CNT_W{1'b0}};
            bubble_cnt_r  <= {CNT_W{1'b0}};
            mispred_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (set_cc_s) begin
                        cc_r <= {bus.e_zf, bus.e_sf, bus.e_of};
                    end
                    stall_cnt_r   <= sat_inc_f(stall_cnt_r, f_stall_s);
                    bubble_cnt_r  <= sat_inc_f(bubble_cnt_r, d_bubble_s || e_bubble_s);
                    mispred_cnt_r <= sat_inc_f(mispred_cnt_r, mp_s);
                    if (exc_f(bus.W_stat)) begin
                        state_r  <= ST_HALTED;
                        halted_r <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    halted_r <= 1'b1;
                end
                default: begin
                    state_r  <= ST_HALTED;
                    halted_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.F_stall     = f_stall_s;
    assign bus.D_stall     = d_stall_s;
    assign bus.W_stall     = w_stall_s;
    assign bus.D_bubble    = d_bubble_s;
    assign bus.E_bubble    = e_bubble_s;
    assign bus.M_bubble    = m_bubble_s;
    assign bus.cc_zf       = cc_r[2];
    assign bus.cc_sf       = cc_r[1];
    assign bus.cc_of       = cc_r[0];
    assign bus.halted      = halted_r;
    assign bus.stall_cnt   = stall_cnt_r;
    assign bus.bubble_cnt  = bubble_cnt_r;
    assign bus.mispred_cnt = mispred_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a behavioural model pushes expected outputs per cycle,
// which are popped and compared against the DUT away from the clock edge.
module tb_pipe_ctrl;
    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    typedef struct packed {
        logic [5:0]    ctl;   // {F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble}
        logic [2:0]    cc;
        logic          halted;
        logic [CW-1:0] sc;
        logic [CW-1:0] bc;
        logic [CW-1:0] mc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(CW)) pif();
    pipe_ctrl #(.CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(pif));

    exp_t sb_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0]    m_cc;
    logic          m_halted;
    logic [CW-1:0] m_sc, m_bc, m_mc;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exc(input logic [3:0] s);
        return s != 4'h1;
    endfunction

    function automatic logic m_lu();
        return ((pif.E_icode == 4'h5) || (pif.E_icode == 4'hB)) && (pif.E_dstM != 4'hF) &&
               ((pif.E_dstM == pif.d_srcA) || (pif.E_dstM == pif.d_srcB));
    endfunction

    function automatic logic m_ret();
        return (pif.D_icode == 4'h9) || (pif.E_icode == 4'h9) || (pif.M_icode == 4'h9);
    endfunction

    function automatic logic m_mp();
        return (pif.E_icode == 4'h7) && !pif.e_cnd;
    endfunction

    function automatic logic [5:0] model_ctl();
        logic lu, rt, mp;
        lu = m_lu(); rt = m_ret(); mp = m_mp();
        if (!rst_n) return 6'b000000;
        if (m_halted) return 6'b111011;
        return {lu | rt, lu, exc(pif.W_stat), mp | (!lu & rt), mp | lu,
                exc(pif.m_stat) | exc(pif.W_stat)};
    endfunction

    function automatic logic [CW-1:0] sat(input logic [CW-1:0] v, input logic en);
        return (en && v != CMAX) ? v + 1'b1 : v;
    endfunction

    task automatic model_reset();
        m_cc = 3'b100; m_halted = 1'b0; m_sc = '0; m_bc = '0; m_mc = '0;
    endtask

    task automatic model_update(input logic [5:0] ctl);
        if (!rst_n) begin
            model_reset();
        end else if (!m_halted) begin
            if (pif.E_icode == 4'h6 && !exc(pif.m_stat) && !exc(pif.W_stat))
                m_cc = {pif.e_zf, pif.e_sf, pif.e_of};
            m_sc = sat(m_sc, ctl[5]);
            m_bc = sat(m_bc, ctl[2] | ctl[1]);
            m_mc = sat(m_mc, m_mp());
            if (exc(pif.W_stat)) m_halted = 1'b1;
        end
    endtask

    // One clock: push expectation, compare on the falling edge, advance the model.
    task automatic tick();
        exp_t e;
        exp_t got;
        e.ctl = model_ctl(); e.cc = m_cc; e.halted = m_halted;
        e.sc = m_sc; e.bc = m_bc; e.mc = m_mc;
        sb_q.push_back(e);
        @(negedge clk);
        got.ctl = {pif.F_stall, pif.D_stall, pif.W_stall, pif.D_bubble, pif.E_bubble, pif.M_bubble};
        e = sb_q.pop_front();
        check_val("ctl", 32'(got.ctl), 32'(e.ctl));
        check_val("cc", 32'({pif.cc_zf, pif.cc_sf, pif.cc_of}), 32'(e.cc));
        check_val("halted", 32'(pif.halted), 32'(e.halted));
        check_val("stall_cnt", 32'(pif.stall_cnt), 32'(e.sc));
        check_val("bubble_cnt", 32'(pif.bubble_cnt), 32'(e.bc));
        check_val("mispred_cnt", 32'(pif.mispred_cnt), 32'(e.mc));
        @(posedge clk);
        model_update(e.ctl);
        #1;
    endtask

    task automatic set_idle();
        pif.D_icode = 4'h1; pif.d_srcA = 4'hF; pif.d_srcB = 4'hF;
        pif.E_icode = 4'h1; pif.E_dstM = 4'hF; pif.e_cnd = 1'b1;
        pif.e_zf = 1'b0; pif.e_sf = 1'b0; pif.e_of = 1'b0;
        pif.M_icode = 4'h1; pif.m_stat = 4'h1; pif.W_stat = 4'h1;
    endtask

    task automatic set_lu();
        pif.E_icode = 4'h5; pif.E_dstM = 4'h3; pif.d_srcB = 4'h3; pif.D_icode = 4'h6;
    endtask

    initial begin
        set_idle();
        rst_n = 1'b0;
        @(posedge clk); #1;
        model_reset();

        // Reset cycle with a load-use hazard presented: controls must stay low.
        set_lu();
        tick();
        rst_n = 1'b1;
        set_idle(); tick();

        // Load-use, then the same with no destination register.
        set_lu(); tick();
        set_idle(); tick();
        set_lu(); pif.E_dstM = 4'hF; tick();
        set_idle(); pif.E_icode = 4'hB; pif.E_dstM = 4'h4; pif.d_srcA = 4'h4; tick();

        // Return travelling through D, E and M.
        set_idle(); pif.D_icode = 4'h9; tick();
        set_idle(); pif.E_icode = 4'h9; tick();
        set_idle(); pif.M_icode = 4'h9; tick();
        set_idle(); tick();

        // Mispredicted jump, alone and alongside a return in decode.
        pif.E_icode = 4'h7; pif.e_cnd = 1'b0; tick();
        set_idle(); pif.E_icode = 4'h7; pif.e_cnd = 1'b1; tick();
        set_idle(); pif.E_icode = 4'h7; pif.e_cnd = 1'b0; pif.D_icode = 4'h9; tick();

        // Condition codes: accepted when clean, blocked by a memory exception.
        set_idle(); pif.E_icode = 4'h6; pif.e_zf = 1'b0; pif.e_sf = 1'b1; tick();
        set_idle(); tick();
        pif.E_icode = 4'h6; pif.e_zf = 1'b1; pif.e_of = 1'b1; pif.m_stat = 4'h3; tick();
        set_idle(); tick();

        // Randomised traffic with occasional memory exceptions.
        for (int i = 0; i < 150; i++) begin
            pif.D_icode = 4'($urandom_range(0, 11));
            pif.d_srcA  = 4'($urandom_range(0, 15));
            pif.d_srcB  = 4'($urandom_range(0, 15));
            pif.E_icode = 4'($urandom_range(0, 11));
            pif.E_dstM  = 4'($urandom_range(0, 15));
            pif.e_cnd   = 1'($urandom_range(0, 1));
            pif.e_zf    = 1'($urandom_range(0, 1));
            pif.e_sf    = 1'($urandom_range(0, 1));
            pif.e_of    = 1'($urandom_range(0, 1));
            pif.M_icode = 4'($urandom_range(0, 11));
            pif.m_stat  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 4)) : 4'h1;
            pif.W_stat  = 4'h1;
            tick();
        end

        // Saturation of the counters under a sustained hazard.
        set_idle(); rst_n = 1'b0; tick();
        rst_n = 1'b1;
        set_lu();
        for (int i = 0; i < 20; i++) tick();
        set_idle(); pif.E_icode = 4'h7; pif.e_cnd = 1'b0;
        for (int i = 0; i < 18; i++) tick();

        // Halt entry, absorbing state, then reset overriding a pending halt.
        set_idle(); rst_n = 1'b0; tick();
        rst_n = 1'b1;
        set_idle(); pif.W_stat = 4'h2; pif.E_icode = 4'h6; pif.e_zf = 1'b0; tick();
        set_idle(); set_lu(); tick();
        set_idle(); pif.E_icode = 4'h7; pif.e_cnd = 1'b0; tick();
        set_idle(); pif.E_icode = 4'h6; tick();
        set_idle(); pif.W_stat = 4'h4; rst_n = 1'b0; tick();
        rst_n = 1'b1;
        set_idle(); tick();
        set_lu(); tick();
        set_idle(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
